// File: rtl/pktx_seq_pkg.sv
// Shared definitions for the TX packet sequencer: field encoding, field
// lengths and the field-presence rules used to walk the packet.
package pktx_pkg;

  localparam int IDX_W            = 13;
  localparam int CRC_BITS         = 16;
  localparam int PYHDR_BITS_1SLOT = 8;
  localparam int PYHDR_BITS_MULTI = 16;
  localparam int AC_BITS_DEF      = 72;
  localparam int HDR_BITS_DEF     = 18;
  localparam int GUARD_US_DEF     = 5;
  localparam int SYNC_SYM_DEF     = 11;
  localparam int TRL_SYM_DEF      = 2;

  typedef enum logic [3:0] {
    PH_IDLE   = 4'd0,
    PH_LATCH  = 4'd1,
    PH_AC     = 4'd2,
    PH_HDR    = 4'd3,
    PH_GUARD  = 4'd4,
    PH_SYNC   = 4'd5,
    PH_PYHDR  = 4'd6,
    PH_PYBODY = 4'd7,
    PH_CRC    = 4'd8,
    PH_TRAIL  = 4'd9,
    PH_HOLD   = 4'd10
  } tx_phase_e;

  // Packet-type snapshot taken from the decode registers.
  typedef struct packed {
    logic [IDX_W-1:0] len;
    logic             ph;
    logic             crc;
    logic             br;
    logic [2:0]       nslot;
  } pk_cfg_t;

  function automatic logic field_present(tx_phase_e f, pk_cfg_t c);
    logic has_py;
    has_py = c.ph | (c.len != '0);
    case (f)
      PH_AC, PH_HDR:     return 1'b1;
      PH_GUARD, PH_SYNC: return ~c.br;
      PH_PYHDR:          return c.ph;
      PH_PYBODY:         return c.len != '0;
      PH_CRC:            return c.crc & has_py;
      PH_TRAIL:          return ~c.br & has_py;
      default:           return 1'b0;
    endcase
  endfunction

  // First present field after cur; HOLD once the packet is exhausted.
  function automatic tx_phase_e next_field(tx_phase_e cur, pk_cfg_t c);
    tx_phase_e n;
    n = PH_HOLD;
    for (int f = int'(PH_TRAIL); f > int'(cur); f--)
      if (field_present(tx_phase_e'(4'(f)), c)) n = tx_phase_e'(4'(f));
    return n;
  endfunction

endpackage

// File: rtl/pktx_seq_if.sv
// Link-controller / encoder side of the TX sequencer.
interface pktx_seq_if;
  logic        tslot_p;
  logic        p_1us;
  logic        tx_req;
  logic        tx_abort;
  logic        bit_req;
  logic [2:0]  occpuy_slots_f;
  logic [12:0] pylenbit_f;
  logic        existpyheader_f;
  logic        crcencode_f;
  logic        packet_BRmode_f;
  logic        pk_encode_1stslot;
  logic [3:0]  tx_phase;
  logic [12:0] bit_idx;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_aborted;
  logic        slot_ovr;

  modport slave (
    input  tslot_p, p_1us, tx_req, tx_abort, bit_req,
           occpuy_slots_f, pylenbit_f, existpyheader_f, crcencode_f, packet_BRmode_f,
    output pk_encode_1stslot, tx_phase, bit_idx, tx_busy, tx_done, tx_aborted, slot_ovr
  );

  modport master (
    output tslot_p, p_1us, tx_req, tx_abort, bit_req,
           occpuy_slots_f, pylenbit_f, existpyheader_f, crcencode_f, packet_BRmode_f,
    input  pk_encode_1stslot, tx_phase, bit_idx, tx_busy, tx_done, tx_aborted, slot_ovr
  );
endinterface

// File: rtl/pktx_seq_fieldcnt.sv
// Bit/symbol index within the current field, advanced either by encoder
// bit requests or by 1 us ticks, with a flag on the final advance.
module pktx_fieldcnt
  import pktx_pkg::*;
(
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             clr,
  input  logic             active,
  input  logic             use_tick,
  input  logic             bit_req,
  input  logic             p_1us,
  input  logic [IDX_W-1:0] len,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic adv;

  assign adv  = active & (use_tick ? p_1us : bit_req);
  assign last = adv & (idx == len - IDX_W'(1));

  // Index restarts at 0 for every field and on abort.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz)              idx <= '0;
    else if (clr || last)   idx <= '0;
    else if (adv)           idx <= idx + IDX_W'(1);
  end

endmodule

// File: rtl/pktx_seq.sv
// Per-transmission sequencer: starts on a slot boundary, walks the packet
// fields for the encoder and keeps TX ownership for the packet's slot count.
module pktx_seq
  import pktx_pkg::*;
#(
  parameter int AC_BITS  = AC_BITS_DEF,
  parameter int HDR_BITS = HDR_BITS_DEF,
  parameter int GUARD_US = GUARD_US_DEF,
  parameter int SYNC_SYM = SYNC_SYM_DEF,
  parameter int TRL_SYM  = TRL_SYM_DEF
) (
  input  logic       clk_6M,
  input  logic       rstz,
  pktx_seq_if.slave  bus
);

  tx_phase_e        st, nxt;
  pk_cfg_t          cfg;
  logic [3:0]       slot_cnt;
  logic [2:0]       nslot;
  logic             slot_reached;
  logic [IDX_W-1:0] flen, idx;
  logic             ftick, fact, flast, abort;
  logic             pk_r, done_r, abt_r, ovr_r;

  assign nslot        = (cfg.nslot == 3'd0) ? 3'd1 : cfg.nslot;
  assign slot_reached = ({1'b0, slot_cnt} + {4'd0, bus.tslot_p}) >= {2'b00, nslot};
  assign abort        = bus.tx_abort & (st != PH_IDLE);
  assign fact         = (st >= PH_AC) && (st <= PH_TRAIL);
  assign nxt          = next_field(st, cfg);

  // Length and advance source of the field currently being sent.
  always_comb begin
    flen  = '0;
    ftick = 1'b0;
    case (st)
      PH_AC:     flen = IDX_W'(AC_BITS);
      PH_HDR:    flen = IDX_W'(HDR_BITS);
      PH_GUARD:  begin flen = IDX_W'(GUARD_US); ftick = 1'b1; end
      PH_SYNC:   begin flen = IDX_W'(SYNC_SYM); ftick = 1'b1; end
      PH_PYHDR:  flen = (cfg.br && nslot == 3'd1) ? IDX_W'(PYHDR_BITS_1SLOT)
                                                  : IDX_W'(PYHDR_BITS_MULTI);
      PH_PYBODY: flen = cfg.len;
      PH_CRC:    flen = IDX_W'(CRC_BITS);
      PH_TRAIL:  begin flen = IDX_W'(TRL_SYM); ftick = 1'b1; end
      default:   ;
    endcase
  end

  pktx_fieldcnt u_fieldcnt (
    .clk_6M   (clk_6M),
    .rstz     (rstz),
    .clr      (abort),
    .active   (fact),
    .use_tick (ftick),
    .bit_req  (bus.bit_req),
    .p_1us    (bus.p_1us),
    .len      (flen),
    .idx      (idx),
    .last     (flast)
  );

  // Sequencer FSM with registered strobes and slot accounting.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      st       <= PH_IDLE;
      cfg      <= '0;
      slot_cnt <= '0;
      pk_r     <= 1'b0;
      done_r   <= 1'b0;
      abt_r    <= 1'b0;
      ovr_r    <= 1'b0;
    end else begin
      pk_r   <= 1'b0;
      done_r <= 1'b0;
      abt_r  <= 1'b0;
      // Decode registers settle the cycle after LATCH; track them through
      // AC, which is long enough that nothing consumes them before HDR ends.
      if (st == PH_AC)
        cfg <= '{len: bus.pylenbit_f, ph: bus.existpyheader_f, crc: bus.crcencode_f,
                 br: bus.packet_BRmode_f, nslot: bus.occpuy_slots_f};
      if (st != PH_IDLE && bus.tslot_p && slot_cnt != 4'hF)
        slot_cnt <= slot_cnt + 4'd1;
      if (abort) begin
        st    <= PH_IDLE;
        abt_r <= 1'b1;
      end else begin
        case (st)
          PH_IDLE:
            if (bus.tslot_p && bus.tx_req) begin
              st    <= PH_LATCH;
              pk_r  <= 1'b1;
              ovr_r <= 1'b0;
            end
          PH_LATCH: begin
            st       <= PH_AC;
            slot_cnt <= '0;
          end
          PH_HOLD:
            if (slot_reached) st <= PH_IDLE;
          default: begin
            if (bus.tslot_p && slot_reached) ovr_r <= 1'b1;
            if (flast) begin
              st     <= nxt;
              done_r <= (nxt == PH_HOLD);
            end
          end
        endcase
      end
    end
  end

  assign bus.pk_encode_1stslot = pk_r;
  assign bus.tx_phase          = st;
  assign bus.bit_idx           = idx;
  assign bus.tx_busy           = (st != PH_IDLE);
  assign bus.tx_done           = done_r;
  assign bus.tx_aborted        = abt_r;
  assign bus.slot_ovr          = ovr_r;

endmodule

// File: tb/tb_pktx_seq.sv
// Directed bench for pktx_seq: a field-queue model predicts every output
// each cycle; literal checks pin field lengths, slot timing and abort.
module tb_pktx_seq;

  localparam int SLOT_PER = 2000;

  logic clk = 1'b0;
  logic rstz = 1'b0;
  always #5 clk = ~clk;

  pktx_seq_if bus ();
  pktx_seq dut (.clk_6M(clk), .rstz(rstz), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  int nprint = 0;
  int cyc = 0;
  int breq_mode = 1;   // 0 none, 1 every cycle, 2 every other cycle

  // Periodic stimulus: slot boundary, 1 us tick, encoder bit pulls.
  initial begin
    bus.tslot_p = 1'b0;
    bus.p_1us   = 1'b0;
    bus.bit_req = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.tslot_p = (cyc % SLOT_PER == 0);
      bus.p_1us   = (cyc % 6 == 0);
      bus.bit_req = (breq_mode == 1) || (breq_mode == 2 && (cyc % 2 == 1));
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct { int ph; int len; bit tick; } fld_t;
  fld_t q[$];
  int m_phase = 0, m_idx = 0, m_slots = 0, m_nslot = 1;
  bit m_pk = 0, m_done = 0, m_abt = 0, m_ovr = 0;

  function automatic void push_fld(int ph, int len, bit tick);
    fld_t f;
    f.ph = ph; f.len = len; f.tick = tick;
    q.push_back(f);
  endfunction

  initial forever begin
    @(posedge clk or negedge rstz);
    if (!rstz) begin
      m_phase = 0; m_idx = 0; m_slots = 0; m_nslot = 1;
      m_pk = 0; m_done = 0; m_abt = 0; m_ovr = 0;
      q.delete();
    end else begin
      m_pk = 0; m_done = 0; m_abt = 0;
      if (bus.tx_abort && m_phase != 0) begin
        m_phase = 0; m_idx = 0; m_abt = 1; q.delete();
      end else if (m_phase == 0) begin
        if (bus.tslot_p && bus.tx_req) begin m_phase = 1; m_pk = 1; m_ovr = 0; end
      end else if (m_phase == 1) begin
        int len; bit ph, crc, br, has_py;
        len = bus.pylenbit_f; ph = bus.existpyheader_f; crc = bus.crcencode_f;
        br = bus.packet_BRmode_f; has_py = ph || len != 0;
        m_nslot = (bus.occpuy_slots_f == 0) ? 1 : int'(bus.occpuy_slots_f);
        m_slots = 0;
        q.delete();
        push_fld(2, 72, 0);
        push_fld(3, 18, 0);
        if (!br) begin push_fld(4, 5, 1); push_fld(5, 11, 1); end
        if (ph) push_fld(6, (br && m_nslot == 1) ? 8 : 16, 0);
        if (len != 0) push_fld(7, len, 0);
        if (crc && has_py) push_fld(8, 16, 0);
        if (!br && has_py) push_fld(9, 2, 1);
        m_phase = q[0].ph; m_idx = 0;
      end else if (m_phase == 10) begin
        if (bus.tslot_p) m_slots++;
        if (m_slots >= m_nslot) m_phase = 0;
      end else begin
        if (bus.tslot_p) begin
          m_slots++;
          if (m_slots >= m_nslot) m_ovr = 1;
        end
        if (q[0].tick ? bus.p_1us : bus.bit_req) begin
          m_idx++;
          if (m_idx == q[0].len) begin
            void'(q.pop_front());
            m_idx = 0;
            if (q.size() == 0) begin m_phase = 10; m_done = 1; end
            else m_phase = q[0].ph;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + observation ----------------
  int hist[16];
  int ticks[16];
  int ndone = 0, nabt = 0;

  always @(negedge clk) begin
    vectors++;
    if (bus.tx_phase !== 4'(m_phase) || bus.bit_idx !== 13'(m_idx) ||
        bus.tx_busy !== (m_phase != 0) || bus.tx_done !== m_done ||
        bus.tx_aborted !== m_abt || bus.slot_ovr !== m_ovr ||
        bus.pk_encode_1stslot !== m_pk) begin
      miscompares++;
      if (nprint < 20)
        $display("FAIL model cyc %0d: phase %0d/%0d idx %0d/%0d busy %b/%b done %b/%b abt %b/%b ovr %b/%b pk %b/%b (got/exp)",
                 cyc, bus.tx_phase, m_phase, bus.bit_idx, m_idx, bus.tx_busy, (m_phase != 0),
                 bus.tx_done, m_done, bus.tx_aborted, m_abt, bus.slot_ovr, m_ovr,
                 bus.pk_encode_1stslot, m_pk);
      nprint++;
    end
    hist[bus.tx_phase]++;
    if (bus.p_1us) ticks[bus.tx_phase]++;
    if (bus.tx_done) ndone++;
    if (bus.tx_aborted) nabt++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 16; i++) begin hist[i] = 0; ticks[i] = 0; end
    ndone = 0; nabt = 0;
  endtask

  // 0 strobe, 1 done, 2 idle, 3 tslot, 4 PYBODY idx 49
  task automatic wait_ev(input int which, input int budget, input string nm);
    int n;
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < budget) begin
      @(negedge clk); n++;
      case (which)
        0: hit = bus.pk_encode_1stslot;
        1: hit = bus.tx_done;
        2: hit = (bus.tx_phase == 4'd0);
        3: hit = bus.tslot_p;
        default: hit = (bus.tx_phase == 4'd7 && bus.bit_idx == 13'd49);
      endcase
    end
    if (!hit) begin
      vectors++; miscompares++;
      $display("FAIL timeout %s after %0d cycles", nm, budget);
    end
  endtask

  task automatic set_cfg(input int len, input bit ph, input bit crc, input bit br, input int ns);
    bus.pylenbit_f      = 13'(len);
    bus.existpyheader_f = ph;
    bus.crcencode_f     = crc;
    bus.packet_BRmode_f = br;
    bus.occpuy_slots_f  = 3'(ns);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s1, s2, n, k;
    bus.tx_req = 1'b0;
    bus.tx_abort = 1'b0;
    set_cfg(0, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_phase", bus.tx_phase, 0);
    check("reset_busy", bus.tx_busy, 0);
    check("reset_idx", bus.bit_idx, 0);
    step(); rstz = 1'b1;

    // BR DM1, plus restart rule at HOLD->IDLE with tx_req held high
    set_cfg(136, 1, 1, 1, 1);
    breq_mode = 1;
    clear_obs();
    step(); bus.tx_req = 1'b1;
    wait_ev(0, 3 * SLOT_PER, "dm1_latch");
    s1 = cyc;
    wait_ev(1, 1000, "dm1_done");
    step();
    check("dm1_ac_cycles", hist[2], 72);
    check("dm1_hdr_cycles", hist[3], 18);
    check("dm1_guard_cycles", hist[4], 0);
    check("dm1_pyhdr_cycles", hist[6], 8);
    check("dm1_body_cycles", hist[7], 136);
    check("dm1_crc_cycles", hist[8], 16);
    check("dm1_done_count", ndone, 1);
    wait_ev(0, 3 * SLOT_PER, "dm1_relatch");
    s2 = cyc;
    check("restart_gap", s2 - s1, 2 * SLOT_PER);
    step(); bus.tx_req = 1'b0;
    wait_ev(2, 3 * SLOT_PER, "dm1_idle");

    // POLL
    set_cfg(0, 0, 1, 1, 1);
    clear_obs();
    step(); bus.tx_req = 1'b1;
    wait_ev(0, 3 * SLOT_PER, "poll_latch");
    step(); bus.tx_req = 1'b0;
    wait_ev(1, 1000, "poll_done");
    step();
    check("poll_ac_cycles", hist[2], 72);
    check("poll_hdr_cycles", hist[3], 18);
    check("poll_pyhdr_cycles", hist[6], 0);
    check("poll_crc_cycles", hist[8], 0);
    wait_ev(2, 3 * SLOT_PER, "poll_idle");

    // EDR 3-DH5
    set_cfg(8000, 1, 1, 0, 5);
    clear_obs();
    step(); bus.tx_req = 1'b1;
    wait_ev(0, 3 * SLOT_PER, "edr_latch");
    step(); bus.tx_req = 1'b0;
    n = 0; k = 0;
    while (bus.tx_busy && k < 7 * SLOT_PER) begin
      @(negedge clk); k++;
      if (bus.tslot_p && bus.tx_busy) n++;
    end
    check("edr_busy_end", bus.tx_busy, 0);
    check("edr_tslots_held", n, 5);
    check("edr_guard_ticks", ticks[4], 5);
    check("edr_sync_ticks", ticks[5], 11);
    check("edr_trail_ticks", ticks[9], 2);
    check("edr_pyhdr_cycles", hist[6], 16);
    check("edr_done_count", ndone, 1);

    // Slot overrun with slow bit pulls
    set_cfg(8000, 1, 1, 1, 1);
    breq_mode = 2;
    clear_obs();
    step(); bus.tx_req = 1'b1;
    wait_ev(0, 3 * SLOT_PER, "ovr_latch");
    step(); bus.tx_req = 1'b0;
    wait_ev(3, 2 * SLOT_PER, "ovr_tslot");
    @(negedge clk);
    check("ovr_set_after_tslot", bus.slot_ovr, 1);
    wait_ev(1, 10 * SLOT_PER, "ovr_done");
    check("ovr_at_done", bus.slot_ovr, 1);
    @(negedge clk);
    check("ovr_idle_after_done", bus.tx_phase, 0);
    breq_mode = 1;

    // Abort in PYBODY at bit_idx 50
    set_cfg(136, 1, 1, 1, 1);
    clear_obs();
    step(); bus.tx_req = 1'b1;
    wait_ev(0, 3 * SLOT_PER, "abt_latch");
    step(); bus.tx_req = 1'b0;
    wait_ev(4, 1000, "abt_body49");
    step(); bus.tx_abort = 1'b1;
    step(); bus.tx_abort = 1'b0;
    @(negedge clk);
    check("abt_pulse", bus.tx_aborted, 1);
    check("abt_phase", bus.tx_phase, 0);
    check("abt_busy", bus.tx_busy, 0);
    check("abt_idx", bus.bit_idx, 0);
    repeat (300) step();
    bus.tx_abort = 1'b1;
    repeat (2) step();
    bus.tx_abort = 1'b0;
    repeat (3) step();
    check("abt_no_done", ndone, 0);
    check("abt_count", nabt, 1);

    // Asynchronous reset mid-packet
    clear_obs();
    step(); bus.tx_req = 1'b1;
    wait_ev(0, 3 * SLOT_PER, "rst_latch");
    step(); bus.tx_req = 1'b0;
    repeat (40) @(posedge clk);
    #3 rstz = 1'b0;
    @(negedge clk);
    check("rst_phase", bus.tx_phase, 0);
    check("rst_busy", bus.tx_busy, 0);
    step(); rstz = 1'b1;
    repeat (20) step();
    check("rst_no_pulses", ndone + nabt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
